// File: rtl/phv_to_pkt_deparser.sv
// PHV-to-packet deparser: rebuilds the 134-bit flit stream by overlaying PHV header slices on buffered flits.
// Optional macro DEPARSER_CONF_DROP_EN: configuration PHV chains (ethertype 9006) are discarded without output.

module phv_to_pkt_deparser_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         wr_ok_o
);
    // Show-ahead; DEPTH is a power of two so the pointers wrap on their own.
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          rd_ok;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign wr_ok_o   = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (wr_ok_o) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_o) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_ok)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(wr_ok_o) - (AW+1)'(rd_ok);
        end
    end
endmodule

module phv_to_pkt_deparser #(
    parameter int HEAD_WIDTH     = 1024,
    parameter int TAG_WIDTH      = 8,
    parameter int TAG_START_BIT  = 0,
    parameter int TAG_TAIL_BIT   = 1,
    parameter int PKT_NUM        = HEAD_WIDTH / 128,
    parameter int PKT_FIFO_DEPTH = 512,
    parameter int PHV_FIFO_DEPTH = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_pkt_valid,
    input  logic [133:0]                    i_pkt,
    input  logic                            i_phv_valid,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_phv,
    output logic                            o_pkt_valid,
    output logic [133:0]                    o_pkt,
    output logic [15:0]                     o_drop_cnt,
    output logic [15:0]                     o_err_cnt,
    output logic [1:0]                      o_fsm_state
);
`ifdef DEPARSER_CONF_DROP_EN
    localparam int CONF_W = 1;
`else
    localparam int CONF_W = 0;
`endif
    localparam int PHV_W = HEAD_WIDTH + TAG_WIDTH + CONF_W;
    localparam int SEG_W = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MERGE, S_DRAIN, S_PASS} state_t;

    // Both input streams are valid-only: a word is taken whenever its valid is high, there is
    // no ready, and a word arriving at a full FIFO is lost and counted in o_drop_cnt.
    logic             pkt_wr_ok, pkt_full, pkt_empty, pkt_pop, pkt_pop_req;
    logic             phv_wr_ok, phv_full, phv_empty, phv_pop, phv_pop_req;
    logic [133:0]     pkt_head;
    logic [PHV_W-1:0] phv_wr_data, phv_head;
    logic             head_conf, pkt_tail, phv_tail;
    logic             pkt_tail_wr, pkt_tail_pop, phv_tail_wr, phv_start_pop;
    logic [127:0]     seg_data [PKT_NUM];

    state_t           state_q, state_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [3:0]       pkt_cnt_q, phv_cnt_q;
    logic [15:0]      drop_cnt_q, err_cnt_q;
    logic [16:0]      drop_sum;
    logic             err_inc;
    logic             out_valid_q, out_valid_d;
    logic [133:0]     out_q, out_d;

`ifdef DEPARSER_CONF_DROP_EN
    // The chain's config flag is decided on its start slice and carried to the rest of it.
    logic conf_chain_q, wr_is_conf, wr_start;
    assign wr_start   = i_phv[HEAD_WIDTH+TAG_START_BIT];
    assign wr_is_conf = wr_start ? (i_phv[HEAD_WIDTH-112 +: 16] == 16'h9006) : conf_chain_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) conf_chain_q <= 1'b0;
        else if (i_phv_valid && wr_start) conf_chain_q <= wr_is_conf;
    end
    assign phv_wr_data = {wr_is_conf, i_phv};
    assign head_conf   = phv_head[PHV_W-1];
`else
    assign phv_wr_data = i_phv;
    assign head_conf   = 1'b0;
`endif

    phv_to_pkt_deparser_fifo #(.W(134), .DEPTH(PKT_FIFO_DEPTH)) u_pkt_fifo (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .wr_en_i(i_pkt_valid), .wr_data_i(i_pkt),
        .rd_en_i(pkt_pop), .rd_data_o(pkt_head), .empty_o(pkt_empty), .full_o(pkt_full),
        .wr_ok_o(pkt_wr_ok)
    );

    phv_to_pkt_deparser_fifo #(.W(PHV_W), .DEPTH(PHV_FIFO_DEPTH)) u_phv_fifo (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .wr_en_i(i_phv_valid), .wr_data_i(phv_wr_data),
        .rd_en_i(phv_pop), .rd_data_o(phv_head), .empty_o(phv_empty), .full_o(phv_full),
        .wr_ok_o(phv_wr_ok)
    );

    // Flit 0 of a slice sits at the top of the header field.
    for (genvar g = 0; g < PKT_NUM; g++) begin : g_seg
        assign seg_data[g] = phv_head[HEAD_WIDTH-1-128*g -: 128];
    end

    assign pkt_pop       = pkt_pop_req && !pkt_empty;
    assign phv_pop       = phv_pop_req && !phv_empty;
    assign pkt_tail      = (pkt_head[133:132] == 2'b10);
    assign phv_tail      = phv_head[HEAD_WIDTH+TAG_TAIL_BIT];
    assign pkt_tail_wr   = pkt_wr_ok && (i_pkt[133:132] == 2'b10);
    assign phv_tail_wr   = phv_wr_ok && i_phv[HEAD_WIDTH+TAG_TAIL_BIT];
    assign pkt_tail_pop  = pkt_pop && pkt_tail;
    assign phv_start_pop = phv_pop && phv_head[HEAD_WIDTH+TAG_START_BIT];
    assign drop_sum      = {1'b0, drop_cnt_q} + 17'(i_pkt_valid && pkt_full)
                                              + 17'(i_phv_valid && phv_full);

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        pkt_pop_req = 1'b0;
        phv_pop_req = 1'b0;
        err_inc     = 1'b0;
        out_valid_d = 1'b0;
        out_d       = out_q;
        case (state_q)
            S_IDLE: begin
                seg_d = '0;
                if (!phv_empty && head_conf && phv_cnt_q != 4'd0) state_d = S_DRAIN;
                else if (pkt_cnt_q != 4'd0 && phv_cnt_q != 4'd0)  state_d = S_MERGE;
            end
            S_MERGE: begin
                pkt_pop_req = 1'b1;
                out_valid_d = 1'b1;
                out_d       = {pkt_head[133:128], seg_data[seg_q]};
                if (pkt_tail) begin
                    // A slice left unfinished is popped here; DRAIN removes the rest of its chain.
                    phv_pop_req = 1'b1;
                    err_inc     = !phv_tail;
                    state_d     = phv_tail ? S_IDLE : S_DRAIN;
                end else if (seg_q == SEG_W'(PKT_NUM - 1)) begin
                    seg_d       = '0;
                    phv_pop_req = 1'b1;
                    if (phv_tail) begin
                        err_inc = 1'b1;
                        state_d = S_PASS;
                    end
                end else begin
                    seg_d = seg_q + SEG_W'(1);
                end
            end
            S_DRAIN: begin
                phv_pop_req = 1'b1;
                if (!phv_empty && phv_tail) state_d = S_IDLE;
            end
            S_PASS: begin
                pkt_pop_req = 1'b1;
                if (!pkt_empty) begin
                    out_valid_d = 1'b1;
                    out_d       = pkt_head;
                    if (pkt_tail) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            seg_q       <= '0;
            pkt_cnt_q   <= '0;
            phv_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            pkt_cnt_q   <= pkt_cnt_q + 4'(pkt_tail_wr) - 4'(pkt_tail_pop);
            phv_cnt_q   <= phv_cnt_q + 4'(phv_tail_wr) - 4'(phv_start_pop);
            drop_cnt_q  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign o_pkt_valid = out_valid_q;
    assign o_pkt       = out_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_fsm_state = state_q;
endmodule

// File: tb/tb_phv_to_pkt_deparser.sv
// Directed bench for phv_to_pkt_deparser: merge, length mismatches, spacing, drops and async reset.
// Build with +define+DEPARSER_CONF_DROP_EN to exercise configuration-chain discard.

module tb_phv_to_pkt_deparser;
    localparam int HW = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pkt_valid = 1'b0;
    logic [133:0]    pkt = '0;
    logic            phv_valid = 1'b0;
    logic [HW+7:0]   phv = '0;
    logic            o_valid;
    logic [133:0]    o_pkt;
    logic [15:0]     drop_cnt;
    logic [15:0]     err_cnt;
    logic [1:0]      fsm_state;

    int              cyc = 0;
    int              last_tail_cyc = 0;
    int              n_checks = 0;
    int              n_errors = 0;
    logic [133:0]    exp_q[$];
    logic [133:0]    got_q[$];
    int              got_cyc_q[$];

    phv_to_pkt_deparser dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_pkt_valid(pkt_valid), .i_pkt(pkt),
        .i_phv_valid(phv_valid), .i_phv(phv),
        .o_pkt_valid(o_valid), .o_pkt(o_pkt),
        .o_drop_cnt(drop_cnt), .o_err_cnt(err_cnt),
        .o_fsm_state(fsm_state)
    );

    // Clock / cycle counter / output capture (sampled on the falling edge).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            got_q.push_back(o_pkt);
            got_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] seg_val(input int pat, input int s, input int g,
                                             input logic [15:0] et);
        if (pat == 'hA5) return {16{8'hA5}};
        return {pat[7:0], s[7:0], g[7:0], 72'h0, et, 16'h0};
    endfunction

    function automatic logic [133:0] pkt_flit(input int id, input int i, input int n);
        logic [1:0] ctl;
        logic [3:0] vb;
        ctl = (i == 0) ? 2'b01 : (i == n - 1) ? 2'b10 : 2'b11;
        vb  = (i == n - 1) ? 4'h5 : 4'hF;
        return {ctl, vb, id[7:0], i[7:0], 112'h0123456789ABCDEF0123456789AB};
    endfunction

    task automatic send_pkt(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pkt_valid = 1'b1;
            pkt       = pkt_flit(id, i, n);
            if (i == n - 1) last_tail_cyc = cyc;
        end
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic send_phv(input int nslices, input int pat, input logic [15:0] et);
        for (int s = 0; s < nslices; s++) begin
            logic [HW-1:0] h;
            logic [7:0]    tag;
            for (int g = 0; g < 8; g++) h[HW-1-128*g -: 128] = seg_val(pat, s, g, et);
            tag = {6'b0, s == nslices - 1, s == 0};
            @(negedge clk);
            phv_valid = 1'b1;
            phv       = {tag, h};
            if (s == nslices - 1) last_tail_cyc = cyc;
        end
        @(negedge clk);
        phv_valid = 1'b0;
    endtask

    // Flits covered by the chain carry PHV data; any beyond it keep their original data.
    task automatic expect_pkt(input int id, input int n, input int nslices, input int pat,
                              input logic [15:0] et);
        for (int i = 0; i < n; i++) begin
            logic [133:0] f;
            f = pkt_flit(id, i, n);
            if (i < 8 * nslices) f[127:0] = seg_val(pat, i / 8, i % 8, et);
            exp_q.push_back(f);
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check(tag, 134'(got_q.size()), 134'(n));
    endtask

    task automatic check_flits(input string tag);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 134'(o_valid), 134'(0));
        check("rst_pkt", o_pkt, 134'(0));
        check("rst_drop", 134'(drop_cnt), 134'(0));
        check("rst_err", 134'(err_cnt), 134'(0));

        // 4-flit packet, 1-slice A5 chain.
        clear_q();
        send_phv(1, 'hA5, 16'h0800);
        send_pkt(1, 4);
        expect_pkt(1, 4, 1, 'hA5, 16'h0800);
        wait_out("t1_count", 4, 40);
        check_flits("t1_flit");
        if (got_cyc_q.size() > 0)
            check("t1_latency", 134'(got_cyc_q[0] - last_tail_cyc), 134'(3));
        check("t1_err", 134'(err_cnt), 134'(0));

        // 12-flit packet, 2-slice chain.
        clear_q();
        send_pkt(2, 12);
        send_phv(2, 'h21, 16'h0800);
        expect_pkt(2, 12, 2, 'h21, 16'h0800);
        wait_out("t2_count", 12, 60);
        check_flits("t2_flit");
        check("t2_err", 134'(err_cnt), 134'(0));

        // Short packet against a long chain, then long packet against a short chain.
        clear_q();
        send_pkt(3, 3);
        send_phv(2, 'h31, 16'h0800);
        expect_pkt(3, 3, 2, 'h31, 16'h0800);
        wait_out("t3a_count", 3, 40);
        check_flits("t3a_flit");
        check("t3a_err", 134'(err_cnt), 134'(1));
        clear_q();
        send_pkt(4, 10);
        send_phv(1, 'h41, 16'h0800);
        expect_pkt(4, 10, 1, 'h41, 16'h0800);
        wait_out("t3b_count", 10, 60);
        check_flits("t3b_flit");
        check("t3b_err", 134'(err_cnt), 134'(2));

        // Back-to-back packets, PHV 20 cycles later.
        clear_q();
        send_pkt(5, 4);
        send_pkt(6, 5);
        repeat (20) @(negedge clk);
        check("t4_wait", 134'(got_q.size()), 134'(0));
        send_phv(1, 'h70, 16'h0800);
        send_phv(1, 'h71, 16'h0800);
        expect_pkt(5, 4, 1, 'h70, 16'h0800);
        expect_pkt(6, 5, 1, 'h71, 16'h0800);
        wait_out("t4_count", 9, 60);
        check_flits("t4_flit");
        if (got_cyc_q.size() == 9) begin
            check("t4_contig_a", 134'(got_cyc_q[3] - got_cyc_q[0]), 134'(3));
            check("t4_gap", 134'(got_cyc_q[4] - got_cyc_q[3]), 134'(2));
            check("t4_contig_b", 134'(got_cyc_q[8] - got_cyc_q[4]), 134'(4));
        end

        // Ethertype 9006 chain.
        clear_q();
`ifdef DEPARSER_CONF_DROP_EN
        send_phv(2, 'h50, 16'h9006);
        send_phv(1, 'h51, 16'h0800);
        send_pkt(7, 4);
        expect_pkt(7, 4, 1, 'h51, 16'h0800);
`else
        send_phv(1, 'h55, 16'h9006);
        send_pkt(7, 4);
        expect_pkt(7, 4, 1, 'h55, 16'h9006);
`endif
        wait_out("t5_count", 4, 40);
        check_flits("t5_flit");
        check("t5_err", 134'(err_cnt), 134'(2));

        // Overfill the PHV FIFO: 5 chains of 4 slices, the last 4 slices are dropped.
        clear_q();
        for (int c = 0; c < 5; c++) send_phv(4, 'h80 + c, 16'h0800);
        repeat (3) @(negedge clk);
        check("t6_drop", 134'(drop_cnt), 134'(4));
        check("t6_quiet", 134'(got_q.size()), 134'(0));

        // Async reset in the middle of MERGE.
        send_pkt(9, 32);
        k = 0;
        while (got_q.size() < 5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t7_started", 134'(got_q.size() >= 5), 134'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_valid", 134'(o_valid), 134'(0));
        check("t7_rst_pkt", o_pkt, 134'(0));
        check("t7_rst_drop", 134'(drop_cnt), 134'(0));
        check("t7_rst_err", 134'(err_cnt), 134'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        repeat (10) @(negedge clk);
        check("t7_idle_after_rst", 134'(got_q.size()), 134'(0));
        send_phv(1, 'h61, 16'h0800);
        send_pkt(10, 4);
        expect_pkt(10, 4, 1, 'h61, 16'h0800);
        wait_out("t7_count", 4, 40);
        check_flits("t7_flit");
        if (got_cyc_q.size() > 0)
            check("t7_latency", 134'(got_cyc_q[0] - last_tail_cyc), 134'(3));
        check("t7_err", 134'(err_cnt), 134'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
